id_ex_skid_reg: RTL and testbench

//   ID/EX pipeline register with a 2-entry skid buffer and valid/ready handshake.

---
 rtl/id_ex_skid_reg.sv | 163 ++++++++++++++++
 tb/tb_id_ex_skid_reg.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_skid_reg.sv
// ---------------------------------------------------------------------------
// id_ex_skid_reg
//   ID/EX pipeline register with a two-entry skid buffer. Decode hands over
//   operands (rs1, rs2, imm, alu_src, rd, pc) through a valid/ready handshake.
//   Execute consumes them the same way. in_ready is a flop, so there is no
//   combinational path from out_ready back to decode. flush drops every held
//   entry, and it also drops an entry that decode transfers in the same cycle.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   flush                 kill all held entries (branch/jump redirect)
//   in_valid / in_ready   decode-side handshake
//   in_rs1/in_rs2/in_imm  XLEN operands from decode
//   in_alu_src            0 = rs2, 1 = imm (execute operand-B mux select)
//   in_rd, in_pc          destination register, instruction PC
//   out_valid / out_ready execute-side handshake
//   out_*                 registered payload (main entry)
//   stall_cnt, flush_cnt  saturating event counters; present only when
//                         IDEX_PERF_CNT_EN is defined
//
// Build option: `define IDEX_PERF_CNT_EN to add the performance counters.
// ---------------------------------------------------------------------------
module id_ex_skid_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_alu_src,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rs1,
  output logic [XLEN-1:0]   out_rs2,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_alu_src,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_pc
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int PW = 4*XLEN + 1 + REG_AW;

  // Encoding chosen so that bit 0 is main_v and bit 1 is skid_v.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t          state, state_nxt;
  logic            in_ready_q;
  logic [PW-1:0]   main_p0, skid_p0, in_pld;
  logic            main_v, skid_v;
  logic            in_xfer, out_xfer;
  logic            ld_main_in, ld_main_skid, ld_skid_in;

  assign main_v   = state[0];
  assign skid_v   = state[1];
  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = main_v & out_ready;
  assign in_pld   = {in_rs1, in_rs2, in_imm, in_alu_src, in_rd, in_pc};

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid_in   = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt  = BUSY;
          ld_main_in = 1'b1;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          ld_main_in = 1'b1;
        end else if (in_xfer) begin
          state_nxt  = FULL;
          ld_skid_in = 1'b1;
        end else if (out_xfer) begin
          state_nxt  = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_nxt    = BUSY;
          ld_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Redirect: everything held or arriving this cycle is discarded. An
    // out-transfer in this cycle has already been taken by execute.
    if (flush) begin
      state_nxt    = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid_in   = 1'b0;
    end
  end

  // ---- stage p0: control flops ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
    end
  end

  // ---- stage p0: payload entries (load only on capture) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      main_p0 <= '0;
      skid_p0 <= '0;
    end else begin
      if (ld_main_in)        main_p0 <= in_pld;
      else if (ld_main_skid) main_p0 <= skid_p0;
      if (ld_skid_in)        skid_p0 <= in_pld;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v;
  assign {out_rs1, out_rs2, out_imm, out_alu_src, out_rd, out_pc} = main_p0;

`ifdef IDEX_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (main_v && !out_ready)       stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush && (main_v || skid_v)) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_skid_reg.sv
module tb_id_ex_skid_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_alu_src, out_valid, out_ready, out_alu_src;
  logic [31:0] in_rs1, in_rs2, in_imm, in_pc, out_rs1, out_rs2, out_imm, out_pc;
  logic [4:0]  in_rd, out_rd;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_skid_reg #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_alu_src(in_alu_src), .in_rd(in_rd), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_alu_src(out_alu_src), .out_rd(out_rd), .out_pc(out_pc)
`ifdef IDEX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // Payload fields are tied to the PC so each instruction is recognisable.
  function automatic logic [31:0] rs1_of(input logic [31:0] pc); return pc + 32'h0000_1000; endfunction
  function automatic logic [31:0] rs2_of(input logic [31:0] pc); return pc ^ 32'hA5A5_0000; endfunction
  function automatic logic [31:0] imm_of(input logic [31:0] pc); return ~pc; endfunction
  function automatic logic [4:0]  rd_of (input logic [31:0] pc); return pc[6:2]; endfunction
  function automatic logic        alu_of(input logic [31:0] pc); return pc[2]; endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [31:0] pc);
    in_valid   = iv;
    out_ready  = ordy;
    flush      = fl;
    in_pc      = pc;
    in_rs1     = rs1_of(pc);
    in_rs2     = rs2_of(pc);
    in_imm     = imm_of(pc);
    in_rd      = rd_of(pc);
    in_alu_src = alu_of(pc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] pc;
    logic        ev;
    logic        eir;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // ---- stream of 8, out_ready high: 1-cycle latency, 1/cycle ----
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b1, 1'b1, 1'b0, 32'(i*4), 1'b1, 1'b1, 32'(i*4)});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0});
    // ---- back-pressure: fill to FULL, hold, drain in order ----
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 32'h10});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 1'b0, 32'h10});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 1'b0, 32'h10});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h10});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h14});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0});
    // ---- flush while FULL, with a new instruction offered ----
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 1'b1, 32'h20});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h24, 1'b1, 1'b0, 32'h20});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h28, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0});
    // ---- flush in BUSY with simultaneous in- and out-transfer ----
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h30, 1'b1, 1'b1, 32'h30});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h34, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0});
    // ---- after flush, a fresh instruction flows normally ----
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h38, 1'b1, 1'b1, 32'h38});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0});

    // ---- reset, load something, reset again mid-transfer ----
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick; tick;
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h40);
    tick;
    drive(1'b1, 1'b0, 1'b0, 32'h44);
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_rs1",   64'(out_rs1),   64'd0);
    chk("rst_out_imm",   64'(out_imm),   64'd0);
    chk("rst_out_pc",    64'(out_pc),    64'd0);
    tick;
    chk("rst_idle_valid", 64'(out_valid), 64'd0);

    // ---- table-driven vectors ----
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].pc);
      tick;
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ev));
      chk($sformatf("v%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].eir));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_out_pc", i),  64'(out_pc),  64'(vecs[i].epc));
        chk($sformatf("v%0d_out_rs1", i), 64'(out_rs1), 64'(rs1_of(vecs[i].epc)));
        chk($sformatf("v%0d_out_rs2", i), 64'(out_rs2), 64'(rs2_of(vecs[i].epc)));
        chk($sformatf("v%0d_out_imm", i), 64'(out_imm), 64'(imm_of(vecs[i].epc)));
        chk($sformatf("v%0d_out_rd", i),  64'(out_rd),  64'(rd_of(vecs[i].epc)));
        chk($sformatf("v%0d_out_alu", i), 64'(out_alu_src), 64'(alu_of(vecs[i].epc)));
      end
    end

    // ---- immediate-select operand pass-through ----
    drive(1'b1, 1'b0, 1'b0, 32'h50);
    in_alu_src = 1'b1;
    in_imm     = 32'hFFFF_FFF0;
    in_rs2     = 32'h0000_0005;
    tick;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("imm_out_valid", 64'(out_valid),   64'd1);
    chk("imm_out_alu",   64'(out_alu_src), 64'd1);
    chk("imm_out_imm",   64'(out_imm),     64'hFFFF_FFF0);
    chk("imm_out_rs2",   64'(out_rs2),     64'h5);
    tick;
    chk("imm_held_imm",  64'(out_imm),     64'hFFFF_FFF0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tick;
    chk("imm_drained",   64'(out_valid),   64'd0);

`ifdef IDEX_PERF_CNT_EN
    // ---- counters: 10 stall cycles, one flush of a held entry ----
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick;
    rst = 1'b0;
    chk("perf_rst_stall", 64'(stall_cnt), 64'd0);
    chk("perf_rst_flush", 64'(flush_cnt), 64'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h60);
    tick;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 10; c++) tick;
    chk("perf_stall_10", 64'(stall_cnt), 64'd10);
    drive(1'b0, 1'b1, 1'b1, 32'h0);
    tick;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("perf_flush_1",  64'(flush_cnt), 64'd1);
    chk("perf_stall_hold", 64'(stall_cnt), 64'd10);
    drive(1'b0, 1'b1, 1'b1, 32'h0);
    tick;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    chk("perf_flush_empty", 64'(flush_cnt), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
